// File: rtl/alu_mc_if.sv
// Request/result handshake bundle for the multi-cycle ALU.
interface alu_mc_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [4:0]      i_op;
  logic [XLEN-1:0] i_a;
  logic [XLEN-1:0] i_b;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_res;
  logic            o_divz;

  modport slave (
    input  i_valid, i_op, i_a, i_b, i_ready,
    output o_ready, o_valid, o_res, o_divz
  );

  modport master (
    output i_valid, i_op, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_res, o_divz
  );
endinterface

// File: rtl/alu_mc.sv
// Handshaked multi-cycle ALU: single-cycle base ops, bit-serial
// multiply (shift-add) and divide (restoring) on operand magnitudes.
module alu_mc #(
  parameter int XLEN = 32
) (
  input  logic     i_clk,
  input  logic     i_rst,
  alu_mc_if.slave  bus
);
  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,  OP_SUB  = 5'd1,  OP_SLL   = 5'd2,  OP_SLT = 5'd3,
    OP_SLTU  = 5'd4,  OP_XOR  = 5'd5,  OP_SRL   = 5'd6,  OP_SRA = 5'd7,
    OP_OR    = 5'd8,  OP_AND  = 5'd9,  OP_MUL   = 5'd10, OP_MULH = 5'd11,
    OP_MULHU = 5'd12, OP_DIV  = 5'd13, OP_DIVU  = 5'd14, OP_REM = 5'd15,
    OP_REMU  = 5'd16
  } op_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4:0]          op_q, op_d;
  logic                negq_q, negq_d;   // negate product / quotient
  logic                negr_q, negr_d;   // negate remainder
  logic [XLEN-1:0]     b_q, b_d;         // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   pair_q, pair_d;   // {acc, multiplier} or {rem, quot}
  logic [XLEN-1:0]     res_q, res_d;
  logic                divz_q, divz_d;

  // Base-op result straight from the request operands
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] base_res;
  always_comb begin
    shamt    = bus.i_b[SHW-1:0];
    base_res = '1;
    case (bus.i_op)
      OP_ADD:  base_res = bus.i_a + bus.i_b;
      OP_SUB:  base_res = bus.i_a - bus.i_b;
      OP_SLL:  base_res = bus.i_a << shamt;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(bus.i_a) < $signed(bus.i_b))};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, (bus.i_a < bus.i_b)};
      OP_XOR:  base_res = bus.i_a ^ bus.i_b;
      OP_SRL:  base_res = bus.i_a >> shamt;
      OP_SRA:  base_res = $signed(bus.i_a) >>> shamt;
      OP_OR:   base_res = bus.i_a | bus.i_b;
      OP_AND:  base_res = bus.i_a & bus.i_b;
      default: base_res = '1;
    endcase
  end

  // Request decode: operand signs and magnitudes for the iterative path
  logic            in_iter, in_div, in_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  always_comb begin
    in_iter   = (bus.i_op >= OP_MUL) && (bus.i_op <= OP_REMU);
    in_div    = (bus.i_op >= OP_DIV) && (bus.i_op <= OP_REMU);
    in_signed = (bus.i_op == OP_MULH) || (bus.i_op == OP_DIV) || (bus.i_op == OP_REM);
    a_neg     = in_signed & bus.i_a[XLEN-1];
    b_neg     = in_signed & bus.i_b[XLEN-1];
    a_mag     = a_neg ? -bus.i_a : bus.i_a;
    b_mag     = b_neg ? -bus.i_b : bus.i_b;
  end

  // One iteration step and the sign-corrected result of the final step
  logic                op_is_div;
  logic [XLEN:0]       add_sum, rem_sh, sub_diff;
  logic [2*XLEN-1:0]   step_res, step_neg;
  logic [XLEN-1:0]     step_hi, step_lo, fin;
  always_comb begin
    op_is_div = (op_q >= OP_DIV);
    add_sum   = {1'b0, pair_q[2*XLEN-1:XLEN]} + {1'b0, ({XLEN{pair_q[0]}} & b_q)};
    rem_sh    = pair_q[2*XLEN-1:XLEN-1];
    sub_diff  = rem_sh - {1'b0, b_q};
    if (op_is_div) begin
      if (sub_diff[XLEN])
        step_res = {rem_sh[XLEN-1:0], pair_q[XLEN-2:0], 1'b0};
      else
        step_res = {sub_diff[XLEN-1:0], pair_q[XLEN-2:0], 1'b1};
    end else begin
      step_res = {add_sum, pair_q[XLEN-1:1]};
    end
    step_neg = -step_res;
    step_hi  = step_res[2*XLEN-1:XLEN];
    step_lo  = step_res[XLEN-1:0];
    case (op_q)
      OP_MUL:   fin = step_lo;
      OP_MULH:  fin = negq_q ? step_neg[2*XLEN-1:XLEN] : step_hi;
      OP_MULHU: fin = step_hi;
      OP_DIV:   fin = negq_q ? step_neg[XLEN-1:0] : step_lo;
      OP_DIVU:  fin = step_lo;
      OP_REM:   fin = negr_q ? -step_hi : step_hi;
      default:  fin = step_hi;
    endcase
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    b_d     = b_q;
    pair_d  = pair_q;
    res_d   = res_q;
    divz_d  = divz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_valid) begin
          op_d   = bus.i_op;
          divz_d = 1'b0;
          if (in_div && (bus.i_b == '0)) begin
            res_d   = ((bus.i_op == OP_DIV) || (bus.i_op == OP_DIVU)) ? '1 : bus.i_a;
            divz_d  = 1'b1;
            state_d = S_DONE;
          end else if (in_iter) begin
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
            cnt_d   = CW'(XLEN);
            // Multiply: multiplier sits in the low half and shifts out;
            // divide: dividend sits in the low half and shifts into the remainder.
            if (in_div) begin
              b_d    = b_mag;
              pair_d = {{XLEN{1'b0}}, a_mag};
            end else begin
              b_d    = a_mag;
              pair_d = {{XLEN{1'b0}}, b_mag};
            end
            state_d = S_BUSY;
          end else begin
            res_d   = base_res;
            state_d = S_DONE;
          end
        end
      end
      S_BUSY: begin
        pair_d = step_res;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_d   = fin;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      b_q     <= '0;
      pair_q  <= '0;
      res_q   <= '0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      b_q     <= b_d;
      pair_q  <= pair_d;
      res_q   <= res_d;
      divz_q  <= divz_d;
    end
  end

  assign bus.o_ready = (state_q == S_IDLE);
  assign bus.o_valid = (state_q == S_DONE);
  assign bus.o_res   = res_q;
  assign bus.o_divz  = divz_q;
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at XLEN=32 and XLEN=16.
module tb_alu_mc;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  alu_mc_if #(.XLEN(32)) bus32 ();
  alu_mc_if #(.XLEN(16)) bus16 ();

  alu_mc #(.XLEN(32)) dut32 (.i_clk(clk), .i_rst(rst), .bus(bus32.slave));
  alu_mc #(.XLEN(16)) dut16 (.i_clk(clk), .i_rst(rst), .bus(bus16.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit w16, input logic v, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (w16) begin
      bus16.i_valid = v; bus16.i_op = op; bus16.i_a = a[15:0]; bus16.i_b = b[15:0];
    end else begin
      bus32.i_valid = v; bus32.i_op = op; bus32.i_a = a; bus32.i_b = b;
    end
  endtask

  function automatic logic [31:0] res_of(input bit w16);
    return w16 ? {16'h0, bus16.o_res} : bus32.o_res;
  endfunction

  function automatic logic valid_of(input bit w16);
    return w16 ? bus16.o_valid : bus32.o_valid;
  endfunction

  // Issue one op, wait (bounded) for the result, check value/flag/latency,
  // then complete the result handshake.
  task automatic run_vec(input string tag, input bit w16, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_divz, input int exp_lat);
    int lat;
    @(negedge clk);
    drive(w16, 1'b1, op, a, b);
    @(posedge clk);
    lat = 1;
    #1;
    drive(w16, 1'b0, 5'd0, ~a, ~b);
    while (!valid_of(w16) && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".valid"}, 32'(valid_of(w16)), 32'd1);
    check({tag, ".res"}, res_of(w16), exp_res);
    check({tag, ".divz"}, 32'(w16 ? bus16.o_divz : bus32.o_divz), 32'(exp_divz));
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    @(negedge clk);
    if (w16) bus16.i_ready = 1'b1; else bus32.i_ready = 1'b1;
    @(posedge clk);
    #1;
    bus16.i_ready = 1'b0;
    bus32.i_ready = 1'b0;
    check({tag, ".ready_after"}, 32'(w16 ? bus16.o_ready : bus32.o_ready), 32'd1);
  endtask

  initial begin
    int lat;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 32'h0);
    bus32.i_ready = 1'b0;
    bus16.i_ready = 1'b0;
    #12;
    check("rst.ready32", 32'(bus32.o_ready), 32'd1);
    check("rst.valid32", 32'(bus32.o_valid), 32'd0);
    check("rst.res32",   bus32.o_res,        32'h0);
    check("rst.divz32",  32'(bus32.o_divz),  32'd0);
    check("rst.ready16", 32'(bus16.o_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Base and illegal ops
    run_vec("add",   0, 5'd0,  32'd7,        32'd5,        32'd12,       0, 1);
    run_vec("sub",   0, 5'd1,  32'd5,        32'd7,        32'hFFFFFFFE, 0, 1);
    run_vec("sll",   0, 5'd2,  32'd1,        32'h21,       32'd2,        0, 1);
    run_vec("sra",   0, 5'd7,  32'h80000000, 32'd4,        32'hF8000000, 0, 1);
    run_vec("srl",   0, 5'd6,  32'h80000000, 32'd31,       32'd1,        0, 1);
    run_vec("slt",   0, 5'd3,  32'hFFFFFFFF, 32'd1,        32'd1,        0, 1);
    run_vec("sltu",  0, 5'd4,  32'hFFFFFFFF, 32'd1,        32'd0,        0, 1);
    run_vec("xor",   0, 5'd5,  32'hF0F0,     32'hFF00,     32'h0FF0,     0, 1);
    run_vec("or",    0, 5'd8,  32'hF0F0,     32'h0F0F,     32'hFFFF,     0, 1);
    run_vec("and",   0, 5'd9,  32'hF0F0,     32'hFF00,     32'hF000,     0, 1);
    run_vec("ill20", 0, 5'd20, 32'd3,        32'd4,        32'hFFFFFFFF, 0, 1);

    // Multiply
    run_vec("mul",    0, 5'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 33);
    run_vec("mulhu",  0, 5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 33);
    run_vec("mulh",   0, 5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 33);
    run_vec("mul2",   0, 5'd10, 32'h12345678, 32'h10,       32'h23456780, 0, 33);
    run_vec("mulhneg",0, 5'd11, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 0, 33);

    // Divide / remainder
    run_vec("div",    0, 5'd13, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 33);
    run_vec("rem",    0, 5'd15, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 33);
    run_vec("div2",   0, 5'd13, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 0, 33);
    run_vec("rem2",   0, 5'd15, 32'd7,        32'hFFFFFFFE, 32'd1,        0, 33);
    run_vec("divu",   0, 5'd14, 32'd100,      32'd7,        32'd14,       0, 33);
    run_vec("remu",   0, 5'd16, 32'd100,      32'd7,        32'd2,        0, 33);
    run_vec("divovf", 0, 5'd13, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 33);
    run_vec("removf", 0, 5'd15, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0, 33);

    // Divide by zero
    run_vec("divu0",  0, 5'd14, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 1);
    run_vec("remu0",  0, 5'd16, 32'd5,        32'd0,        32'd5,        1, 1);
    run_vec("div0",   0, 5'd13, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1, 1);
    run_vec("rem0",   0, 5'd15, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1, 1);

    // Backpressure with a dropped request during the hold
    @(negedge clk);
    drive(0, 1'b1, 5'd14, 32'd5, 32'd0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 5'd0, 32'h0, 32'h0);
    check("bp.valid", 32'(bus32.o_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) drive(0, 1'b1, 5'd0, 32'd1, 32'd1);
      else        drive(0, 1'b0, 5'd0, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      check("bp.res",   bus32.o_res,           32'hFFFFFFFF);
      check("bp.divz",  32'(bus32.o_divz),     32'd1);
      check("bp.ready", 32'(bus32.o_ready),    32'd0);
      check("bp.valid_hold", 32'(bus32.o_valid), 32'd1);
    end
    @(negedge clk);
    drive(0, 1'b0, 5'd0, 32'h0, 32'h0);
    bus32.i_ready = 1'b1;
    @(posedge clk);
    #1;
    bus32.i_ready = 1'b0;
    check("bp.ready_after", 32'(bus32.o_ready), 32'd1);
    check("bp.valid_after", 32'(bus32.o_valid), 32'd0);
    @(posedge clk);
    #1;
    check("bp.dropped", 32'(bus32.o_valid), 32'd0);

    // Asynchronous reset in the middle of a multiply
    @(negedge clk);
    drive(0, 1'b1, 5'd10, 32'd9, 32'd9);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 5'd0, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) @(posedge clk);
    #3;
    check("arst.pre_busy", 32'(bus32.o_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("arst.valid", 32'(bus32.o_valid), 32'd0);
    check("arst.ready", 32'(bus32.o_ready), 32'd1);
    check("arst.res",   bus32.o_res,        32'h0);
    check("arst.divz",  32'(bus32.o_divz),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec("mul34", 0, 5'd10, 32'd3, 32'd4, 32'd12, 0, 33);

    // Narrow instance
    run_vec("m16.mul",    1, 5'd10, 32'hFFFF, 32'hFFFF, 32'h0001, 0, 17);
    run_vec("m16.mulhu",  1, 5'd12, 32'hFFFF, 32'hFFFF, 32'hFFFE, 0, 17);
    run_vec("m16.mulh",   1, 5'd11, 32'hFFFF, 32'hFFFF, 32'h0000, 0, 17);
    run_vec("m16.div",    1, 5'd13, 32'hFFF9, 32'd2,    32'hFFFD, 0, 17);
    run_vec("m16.rem",    1, 5'd15, 32'hFFF9, 32'd2,    32'hFFFF, 0, 17);
    run_vec("m16.divu",   1, 5'd14, 32'd100,  32'd7,    32'd14,   0, 17);
    run_vec("m16.remu",   1, 5'd16, 32'd100,  32'd7,    32'd2,    0, 17);
    run_vec("m16.divovf", 1, 5'd13, 32'h8000, 32'hFFFF, 32'h8000, 0, 17);
    run_vec("m16.removf", 1, 5'd15, 32'h8000, 32'hFFFF, 32'h0000, 0, 17);
    run_vec("m16.sra",    1, 5'd7,  32'h8000, 32'h14,   32'hF800, 0, 1);

    lat = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised, handshaked, multi-cycle ALU for the CPU execute stage. It supports the base integer ops plus M-extension multiply, divide and remainder. Base ops complete in one cycle. Multiply and divide run iteratively, one bit per cycle, so no wide combinational multiplier or divider is needed. The block holds one operation at a time and uses a valid/ready handshake on both input and output.

Parameters:
XLEN, 32, operand/result width; power of two, minimum 8.
SHW, $clog2(XLEN), shift-amount width (derived, not overridden).

Ports:
i_clk  input  1  clock, rising edge.
i_rst  input  1  reset, asynchronous, active-high.
i_valid  input  1  request valid.
o_ready  output  1  block can accept a request.
i_op  input  5  operation code (see Behaviour).
i_a  input  XLEN  operand A (dividend / multiplicand).
i_b  input  XLEN  operand B (divisor / multiplier / shift amount).
o_valid  output  1  result valid.
i_ready  input  1  consumer accepts result.
o_res  output  XLEN  result.
o_divz  output  1  divide-by-zero flag; meaningful only while o_valid=1.

Behaviour:
- Op codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 10 MUL (low XLEN of product), 11 MULH (signed×signed, high XLEN), 12 MULHU (unsigned high XLEN).
  - 13 DIV, 14 DIVU, 15 REM, 16 REMU.
  - 17..31 illegal: result all ones, 1-cycle latency.
- Shifts use i_b[SHW-1:0]. SLT/SLTU give result 1 or 0, zero-extended. Add/sub wrap modulo 2^XLEN.
- FSM states:
  - IDLE: o_ready=1, o_valid=0. Accept occurs when i_valid=1 in IDLE. Operands and op are latched at accept; later input changes are ignored.
    - Base, illegal, or divide-by-zero op accepted → DONE next cycle.
    - MUL/MULH/MULHU/DIV/DIVU/REM/REMU with b≠0 → BUSY, counter loaded with XLEN.
  - BUSY: o_ready=0, o_valid=0. One shift-add (mul) or restoring-subtract (div) step per cycle on operand magnitudes. Counter decrements each cycle; at 0 → DONE.
  - DONE: o_valid=1, o_ready=0. o_res and o_divz are held stable until i_ready=1 is sampled, then → IDLE.
- Latency (accept edge to first o_valid=1 cycle):
  - 1 cycle for base, illegal and divide-by-zero ops.
  - XLEN+1 cycles for mul/div/rem.
- Throughput: one op in flight. There is no accept in the same cycle as the result handshake; the earliest next accept is one cycle after the handshake.
- Signed ops:
  - Take absolute values and run the unsigned iteration on a 2×XLEN product or quotient/remainder pair.
  - Negate the product/quotient if operand signs differ; negate the remainder if the dividend is negative.
- Overflow: DIV(MIN, −1) = MIN and REM(MIN, −1) = 0. These fall out of the magnitude method; no special case.
- Divide by zero (b=0, ops 13–16): detected at accept, short-circuit to DONE.
  - DIV/DIVU result = all ones; REM/REMU result = dividend.
  - o_divz=1. o_divz=0 for every other case.
- Reset: i_rst=1 at any time (including mid-BUSY or DONE) immediately forces IDLE, o_valid=0, o_ready=1, o_res=0, o_divz=0, counter=0. The in-flight op is discarded. First accept is possible on the first clock edge after i_rst deasserts.
- i_valid while o_ready=0 is ignored; nothing is queued.

Test Plan:
1. XLEN=32. ADD 7,5 → o_valid 1 cycle after accept, o_res=12. SRA 0x80000000,4 → 0xF8000000. SLT 0xFFFFFFFF,1 → 1. SLTU same operands → 0. Op 20 → 0xFFFFFFFF.
2. a=b=0xFFFFFFFF: MUL → 0x00000001, MULHU → 0xFFFFFFFE, MULH → 0x00000000. o_valid exactly 33 cycles after accept in each case.
3. DIV −7,2 → 0xFFFFFFFD. REM −7,2 → 0xFFFFFFFF. DIVU 100,7 → 14. REMU 100,7 → 2. DIV 0x80000000,0xFFFFFFFF → 0x80000000 with REM = 0.
4. Divide by zero: DIVU 5,0 → 0xFFFFFFFF. REMU 5,0 → 5. DIV −5,0 → 0xFFFFFFFF. REM −5,0 → 0xFFFFFFFB. All with o_divz=1 and 1-cycle latency.
5. Backpressure: hold i_ready=0 for 10 cycles after o_valid → o_res/o_divz stable, o_ready=0, and an i_valid pulse during the hold is dropped. On i_ready=1, o_ready=1 the next cycle.
6. Assert i_rst asynchronously 10 cycles into a MUL → o_valid=0, o_ready=1, o_res=0 without a clock edge. A following MUL 3,4 → 12 after 33 cycles. Repeat scenarios 2–3 with XLEN=16: MULHU 0xFFFF,0xFFFF → 0xFFFE, latency 17.
